mdf_rs: RTL
===========

Name: mdf_rs

Overview:
Reservation station in front of the multiply/divide functional unit in the Tomasulo core. It accepts issued instructions and captures operands, either directly or from common data bus (CDB) broadcasts. It dispatches ready entries to the mdf unit through its enable/finished/result-acknowledge handshake, then requests the CDB to broadcast each result. This block is the initiator and result-consumer side of the handshake the mdf unit responds to.

Parameters:
ENTRIES, 3, number of station entries (2..7)
TAG_BASE, 1, tag of entry 0; entry i has tag TAG_BASE+i; tag 0 means "value ready"
TW, 4, tag width
OPW, 2, opcode width

Ports:
clk  input  1  clock, rising edge
nRST  input  1  asynchronous active-low reset
issueEN  input  1  issue request; accepted only when full==0
issueOp  input  OPW  operation code
issueVj  input  32  operand 1 value (valid when issueQj==0)
issueQj  input  TW  operand 1 producer tag
issueVk  input  32  operand 2 value
issueQk  input  TW  operand 2 producer tag
full  output  1  no free entry (registered state only)
issueTag  output  TW  tag assigned to the next accepted issue (lowest free entry)
cdbValid  input  1  CDB broadcast valid
cdbTag  input  TW  broadcasting tag
cdbData  input  32  broadcast value
fuEN  output  1  start pulse to mdf unit
fuOp  output  OPW  opcode to mdf unit
fuData1  output  32  operand 1
fuData2  output  32  operand 2
fuFinished  input  1  mdf unit result ready (level, held until acknowledged)
fuResult  input  32  mdf unit result
fuResultAC  output  1  result acknowledge pulse to mdf unit
cdbReq  output  1  request CDB
cdbReqTag  output  TW  tag of result
cdbReqData  output  32  result value
cdbGrant  input  1  arbiter grant for current request

Behaviour:
- Reset (async, nRST=0): all entries invalid, controller IDLE. fuEN, fuResultAC and cdbReq are 0. fuOp, fuData1, fuData2, cdbReqTag and cdbReqData are 0. full=0, issueTag=TAG_BASE.
- Entry fields: busy, op, Vj, Qj, Vk, Qk, dispatched.
- Issue: on a clock edge with issueEN=1 and full=0, write the lowest-index free entry. Simultaneous CDB forwarding: if cdbValid=1 and cdbTag equals a nonzero issueQj or issueQk, store cdbData and set Q to 0 in the same edge.
- issueEN=1 while full=1 is ignored and leaves no state change.
- CDB snoop: every edge with cdbValid=1, any busy entry with Qj==cdbTag (nonzero) takes Vj=cdbData and Qj=0. Same rule for Qk.
- An entry freed on an edge becomes reusable from the following cycle. full reflects registered busy bits only; there is no same-cycle bypass.
- Controller FSM:
  - IDLE: select the lowest-index entry with busy, !dispatched, Qj==0, Qk==0. If one exists, assert fuEN for exactly one cycle with fuOp/fuData1/fuData2 from that entry, latch its index, mark it dispatched, and go to RUN. An entry made ready by the CDB on this edge is eligible next cycle.
  - RUN: fuEN=0. On fuFinished=1, latch fuResult into cdbReqData and the entry tag into cdbReqTag, pulse fuResultAC for one cycle, and go to BCAST.
  - BCAST: cdbReq=1 with stable tag and data. On cdbGrant=1, drop cdbReq next cycle, free the entry, and return to IDLE. No new dispatch happens on the grant edge.
- The station does not snoop its own broadcast back into itself. Dependent entries in this station still capture it via the cdbValid path driven by the arbiter.
- Dispatch-to-free minimum: fuEN cycle, at least one RUN cycle, the BCAST cycle(s), then free.
- Arithmetic is not performed here. Widths pass through unchanged.
- Reset mid-operation clears everything immediately. The mdf unit is reset by the same nRST.

Test Plan:
- Reset while cdbReq=1 -> next cycle all outputs 0, full=0, issueTag=1.
- Issue op=00, Vj=5, Vk=10, Q=0 -> fuEN pulses next cycle with fuData1=5 and fuData2=10. With fuFinished and fuResult=50: fuResultAC pulses for one cycle, then cdbReq=1, tag=1, data=50. Grant -> entry freed, full=0.
- Issue with Qj=7 while cdbValid=1, cdbTag=7, cdbData=3 on the same edge -> captured. Dispatch shows fuData1=3 with no further wait.
- Issue three dependent entries (Qj=9) -> full=1. A 4th issueEN is ignored. Broadcast tag 9 value 2 -> entries dispatch in order tags 1, 2, 3.
- Hold cdbGrant=0 for 5 cycles in BCAST -> cdbReq, tag and data stay stable, no second fuEN. Grant -> the next dispatch follows.
- Entry 0 waiting on a tag while entry 1 is ready -> entry 1 dispatched first (tag 2).

Source files
------------

// File: rtl/mdf_rs.sv
// mdf_rs: reservation station that captures operands from issue/CDB, dispatches
// ready entries to the mdf unit and requests the CDB for each result.
module mdf_rs #(
  parameter int ENTRIES = 3,
  parameter int TAG_BASE = 1,
  parameter int TW = 4,
  parameter int OPW = 2
) (
  input  logic           clk,
  input  logic           nRST,
  input  logic           issueEN,
  input  logic [OPW-1:0] issueOp,
  input  logic [31:0]    issueVj,
  input  logic [TW-1:0]  issueQj,
  input  logic [31:0]    issueVk,
  input  logic [TW-1:0]  issueQk,
  output logic           full,
  output logic [TW-1:0]  issueTag,
  input  logic           cdbValid,
  input  logic [TW-1:0]  cdbTag,
  input  logic [31:0]    cdbData,
  output logic           fuEN,
  output logic [OPW-1:0] fuOp,
  output logic [31:0]    fuData1,
  output logic [31:0]    fuData2,
  input  logic           fuFinished,
  input  logic [31:0]    fuResult,
  output logic           fuResultAC,
  output logic           cdbReq,
  output logic [TW-1:0]  cdbReqTag,
  output logic [31:0]    cdbReqData,
  input  logic           cdbGrant
);
  localparam int IW = $clog2(ENTRIES);
  typedef enum logic [1:0] {IDLE, RUN, BCAST} state_t;
  state_t state, stateNext;
  logic busy [ENTRIES];
  logic disp [ENTRIES];
  logic [OPW-1:0] op [ENTRIES];
  logic [31:0] vj [ENTRIES];
  logic [31:0] vk [ENTRIES];
  logic [TW-1:0] qj [ENTRIES];
  logic [TW-1:0] qk [ENTRIES];
  logic [IW-1:0] freeIdx, readyIdx, curIdx;
  logic hasFree, hasReady, doIssue, fwdJ, fwdK;
  // descending scan so the lowest matching index wins
  always_comb begin
    hasFree = 1'b0;
    freeIdx = '0;
    hasReady = 1'b0;
    readyIdx = '0;
    for (int i = ENTRIES - 1; i >= 0; i--) begin
      if (!busy[i]) begin
        hasFree = 1'b1;
        freeIdx = IW'(i);
      end
      if (busy[i] && !disp[i] && qj[i] == '0 && qk[i] == '0) begin
        hasReady = 1'b1;
        readyIdx = IW'(i);
      end
    end
  end
  assign full = !hasFree;
  assign issueTag = TW'(TAG_BASE) + TW'(freeIdx);
  assign doIssue = issueEN && hasFree;
  assign fwdJ = cdbValid && issueQj != '0 && issueQj == cdbTag;
  assign fwdK = cdbValid && issueQk != '0 && issueQk == cdbTag;
  always_comb begin
    stateNext = state;
    fuEN = 1'b0;
    fuOp = '0;
    fuData1 = '0;
    fuData2 = '0;
    fuResultAC = 1'b0;
    cdbReq = 1'b0;
    if (state == IDLE && hasReady) begin
      fuEN = 1'b1;
      fuOp = op[readyIdx];
      fuData1 = vj[readyIdx];
      fuData2 = vk[readyIdx];
      stateNext = RUN;
    end
    if (state == RUN && fuFinished) begin
      fuResultAC = 1'b1;
      stateNext = BCAST;
    end
    if (state == BCAST) begin
      cdbReq = 1'b1;
      stateNext = cdbGrant ? IDLE : BCAST;
    end
  end
  always_ff @(posedge clk or negedge nRST) begin
    if (!nRST) begin
      state <= IDLE;
      curIdx <= '0;
      cdbReqTag <= '0;
      cdbReqData <= '0;
      for (int i = 0; i < ENTRIES; i++) begin
        busy[i] <= 1'b0;
        disp[i] <= 1'b0;
        op[i] <= '0;
        vj[i] <= '0;
        vk[i] <= '0;
        qj[i] <= '0;
        qk[i] <= '0;
      end
    end else begin
      state <= stateNext;
      if (fuEN) curIdx <= readyIdx;
      if (fuResultAC) begin
        cdbReqTag <= TW'(TAG_BASE) + TW'(curIdx);
        cdbReqData <= fuResult;
      end
      for (int i = 0; i < ENTRIES; i++) begin
        if (doIssue && freeIdx == IW'(i)) begin
          busy[i] <= 1'b1;
          disp[i] <= 1'b0;
          op[i] <= issueOp;
          vj[i] <= fwdJ ? cdbData : issueVj;
          qj[i] <= fwdJ ? '0 : issueQj;
          vk[i] <= fwdK ? cdbData : issueVk;
          qk[i] <= fwdK ? '0 : issueQk;
        end else if (busy[i]) begin
          if (cdbValid && qj[i] != '0 && qj[i] == cdbTag) begin
            vj[i] <= cdbData;
            qj[i] <= '0;
          end
          if (cdbValid && qk[i] != '0 && qk[i] == cdbTag) begin
            vk[i] <= cdbData;
            qk[i] <= '0;
          end
          if (fuEN && readyIdx == IW'(i)) disp[i] <= 1'b1;
          if (cdbReq && cdbGrant && curIdx == IW'(i)) busy[i] <= 1'b0;
        end
      end
    end
  end
endmodule
